// File: rtl/pwm_key_ctrl.sv
// Key-driven PWM controller: run/stop, tick divider select and duty up/down with
// hold-to-repeat. Duty is shadowed per period so pwm_out only changes at a wrap.
module pwm_key_ctrl #(
  parameter int DUTY_W     = 8,
  parameter int STEP       = 8,
  parameter int DUTY_INIT  = 128,
  parameter int HOLD_CYC   = 25_000_000,
  parameter int REPEAT_CYC = 5_000_000
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [3:0]        press,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty,
  output logic              running,
  output logic [1:0]        div_sel,
  output logic              period_end
);

  localparam int MAX_CYC = (HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC;
  localparam int RCNT_W  = $clog2(MAX_CYC + 1);
  localparam logic [RCNT_W-1:0] HOLD_LAST = RCNT_W'(HOLD_CYC - 1);
  localparam logic [RCNT_W-1:0] REP_LAST  = RCNT_W'(REPEAT_CYC - 1);
  localparam logic [DUTY_W:0]   STEP_X    = (DUTY_W + 1)'(STEP);
  localparam logic [DUTY_W:0]   DUTY_MAX  = {1'b0, {DUTY_W{1'b1}}};

  typedef enum logic {STOP, RUN} state_e;
  typedef enum logic [1:0] {R_IDLE, R_HOLD, R_REPEAT} rstate_e;

  state_e              state_q, state_d;
  rstate_e             rstate_q, rstate_d;
  logic                rkey_q, rkey_d;
  logic [RCNT_W-1:0]   rcnt_q, rcnt_d;
  logic [3:0]          press_q, press_d;
  logic [3:0]          ign_q, ign_d;
  logic [DUTY_W-1:0]   duty_q, duty_d;
  logic [DUTY_W-1:0]   da_q, da_d;
  logic [DUTY_W-1:0]   cnt_q, cnt_d;
  logic [1:0]          div_sel_q, div_sel_d;
  logic [2:0]          presc_q, presc_d;
  logic                pwm_q, pwm_d;
  logic                pe_q, pe_d;

  logic [3:0]          ev;
  logic                up_ok, dn_ok, key_held, opp_held;
  logic                step, step_dn;
  logic [2:0]          tick_mask;
  logic                tick, wrap;
  logic [DUTY_W:0]     duty_x;

  // Keys held through reset stay masked in ign_q until they are released.
  always_comb begin
    press_d   = press;
    ign_d     = ign_q & press;
    ev        = press & ~press_q & ~ign_q;
    up_ok     = ev[0] && !press[1];
    dn_ok     = ev[1] && !press[0];
    state_d   = state_q;
    if (ev[2]) state_d = (state_q == STOP) ? RUN : STOP;
    div_sel_d = ev[3] ? div_sel_q + 2'd1 : div_sel_q;
  end

  always_comb begin
    rstate_d = rstate_q;
    rkey_d   = rkey_q;
    rcnt_d   = rcnt_q;
    step     = 1'b0;
    step_dn  = rkey_q;
    key_held = rkey_q ? press[1] : press[0];
    opp_held = rkey_q ? press[0] : press[1];
    unique case (rstate_q)
      R_IDLE: begin
        if (up_ok || dn_ok) begin
          step     = 1'b1;
          step_dn  = dn_ok;
          rkey_d   = dn_ok;
          rstate_d = R_HOLD;
          rcnt_d   = '0;
        end
      end
      R_HOLD, R_REPEAT: begin
        if (!key_held || opp_held) begin
          rstate_d = R_IDLE;
          rcnt_d   = '0;
        end else if (rcnt_q == ((rstate_q == R_HOLD) ? HOLD_LAST : REP_LAST)) begin
          step     = 1'b1;
          rstate_d = R_REPEAT;
          rcnt_d   = '0;
        end else begin
          rcnt_d   = rcnt_q + RCNT_W'(1);
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

  always_comb begin
    duty_x = {1'b0, duty_q};
    duty_d = duty_q;
    if (step) begin
      if (step_dn) duty_d = (duty_x < STEP_X) ? '0 : DUTY_W'(duty_x - STEP_X);
      else         duty_d = (duty_x + STEP_X > DUTY_MAX) ? '1 : DUTY_W'(duty_x + STEP_X);
    end
  end

  // Tick fires when the low div_sel bits of the prescaler are all ones.
  always_comb begin
    tick_mask = ~(3'b111 << div_sel_q);
    tick      = (state_q == RUN) && ((presc_q & tick_mask) == tick_mask);
    wrap      = tick && (cnt_q == '1);
    presc_d   = (state_q == RUN) ? presc_q + 3'd1 : '0;
    cnt_d     = tick ? cnt_q + DUTY_W'(1) : cnt_q;
    da_d      = da_q;
    if (wrap || (state_q == STOP && state_d == RUN)) da_d = duty_q;
    if (state_d == STOP) begin
      presc_d = '0;
      cnt_d   = '0;
    end
    pe_d      = wrap && (state_d == RUN);
    pwm_d     = (state_d == RUN) && (cnt_d < da_d);
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= STOP;
      rstate_q  <= R_IDLE;
      rkey_q    <= 1'b0;
      rcnt_q    <= '0;
      press_q   <= '0;
      ign_q     <= press;
      duty_q    <= DUTY_W'(DUTY_INIT);
      da_q      <= '0;
      cnt_q     <= '0;
      div_sel_q <= '0;
      presc_q   <= '0;
      pwm_q     <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rstate_q  <= rstate_d;
      rkey_q    <= rkey_d;
      rcnt_q    <= rcnt_d;
      press_q   <= press_d;
      ign_q     <= ign_d;
      duty_q    <= duty_d;
      da_q      <= da_d;
      cnt_q     <= cnt_d;
      div_sel_q <= div_sel_d;
      presc_q   <= presc_d;
      pwm_q     <= pwm_d;
      pe_q      <= pe_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign duty       = duty_q;
  assign running    = (state_q == RUN);
  assign div_sel    = div_sel_q;
  assign period_end = pe_q;

endmodule

// File: tb/tb_pwm_key_ctrl.sv
// Bench for pwm_key_ctrl: elapsed-count reference model checked every cycle,
// plus directed key sequences with literal expectations.
module tb_pwm_key_ctrl;

  localparam int STEP = 8;
  localparam int HOLD = 10;
  localparam int REP  = 4;

  logic       clk = 1'b0;
  logic       n_reset;
  logic [3:0] press;
  logic       pwm_out;
  logic [7:0] duty;
  logic       running;
  logic [1:0] div_sel;
  logic       period_end;

  pwm_key_ctrl #(
    .DUTY_W(8), .STEP(STEP), .DUTY_INIT(128), .HOLD_CYC(HOLD), .REPEAT_CYC(REP)
  ) dut (
    .clk(clk), .n_reset(n_reset), .press(press), .pwm_out(pwm_out), .duty(duty),
    .running(running), .div_sel(div_sel), .period_end(period_end)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: C = clk cycles spent in RUN, T = ticks since RUN start,
  // held = cycles the accepted key has stayed down.
  int         m_duty, m_da, m_div, m_c, m_t, m_held, m_key, m_old;
  bit         m_run, m_pe, m_valid = 0, m_was, m_tick, m_wrap, m_step, m_dn;
  logic [3:0] m_prev, m_ign, m_rise;

  always @(posedge clk) begin
    if (!n_reset) begin
      m_duty = 128; m_da = 0; m_div = 0; m_c = 0; m_t = 0; m_held = 0; m_key = -1;
      m_run = 0; m_pe = 0; m_prev = '0; m_ign = press; m_valid = 1;
    end else begin
      m_rise = press & ~m_prev & ~m_ign;
      m_ign  = m_ign & press;
      m_prev = press;
      m_step = 0; m_dn = 0;
      if (m_key >= 0) begin
        if (!press[m_key] || press[1 - m_key]) m_key = -1;
        else begin
          m_held++;
          if (m_held == HOLD || (m_held > HOLD && (m_held - HOLD) % REP == 0)) begin
            m_step = 1; m_dn = (m_key == 1);
          end
        end
      end else if (m_rise[0] && !press[1]) begin
        m_key = 0; m_held = 0; m_step = 1;
      end else if (m_rise[1] && !press[0]) begin
        m_key = 1; m_held = 0; m_step = 1; m_dn = 1;
      end
      m_old  = m_duty;
      m_was  = m_run;
      m_tick = m_was && ((m_c % (1 << m_div)) == (1 << m_div) - 1);
      m_wrap = 0;
      if (m_tick) begin
        m_t++;
        m_wrap = (m_t % 256 == 0);
      end
      if (m_step)
        m_duty = m_dn ? ((m_duty < STEP) ? 0 : m_duty - STEP)
                      : ((m_duty + STEP > 255) ? 255 : m_duty + STEP);
      if (m_rise[3]) m_div = (m_div + 1) % 4;
      if (m_rise[2]) m_run = !m_run;
      if (m_was) m_c++;
      if ((!m_was && m_run) || m_wrap) m_da = m_old;
      if (!m_run) begin m_c = 0; m_t = 0; end
      m_pe = m_wrap && m_run;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("m_pwm_out", pwm_out, (m_run && (m_t % 256) < m_da) ? 1 : 0);
      chk("m_duty", duty, m_duty);
      chk("m_running", running, m_run);
      chk("m_div_sel", div_sel, m_div);
      chk("m_period_end", period_end, m_pe);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input int k);
    press[k] = 1'b1;
    @(negedge clk);
    press[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_pe(output bit ok);
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (period_end) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Starts on a period_end cycle; returns cycles to the next one and high count.
  task automatic measure(output int len, output int hi);
    len = 0; hi = 0;
    do begin
      hi += int'(pwm_out);
      @(negedge clk);
      len++;
    end while (!period_end && len < 3000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int len, hi;
    press = '0; n_reset = 1'b0;
    cyc(3);
    chk("rst_duty", duty, 128);
    chk("rst_running", running, 0);
    chk("rst_pwm", pwm_out, 0);
    chk("rst_div", div_sel, 0);
    chk("rst_pe", period_end, 0);
    n_reset = 1'b1;
    cyc(2);

    pulse(2);
    chk("run_on", running, 1);
    wait_pe(ok); chk("pe_seen_1", ok, 1);
    measure(len, hi);
    chk("period_div0", len, 256);
    chk("high_div0", hi, 128);

    repeat (15) pulse(0); chk("duty_248", duty, 248);
    pulse(0); chk("sat_up_1", duty, 255);
    pulse(0); chk("sat_up_2", duty, 255);
    repeat (32) pulse(1); chk("down_to_0", duty, 0);
    pulse(0); chk("duty_8", duty, 8);
    pulse(1); chk("sat_dn_1", duty, 0);
    pulse(1); chk("sat_dn_2", duty, 0);
    wait_pe(ok); chk("pe_seen_2", ok, 1);
    hi = 0;
    repeat (300) begin
      hi += int'(pwm_out);
      @(negedge clk);
    end
    chk("low_after_wrap", hi, 0);

    press[0] = 1'b1;
    cyc(12); chk("hold_2steps", duty, 16);
    cyc(18);
    press[0] = 1'b0;
    @(negedge clk); chk("hold_48", duty, 48);
    cyc(20); chk("hold_release", duty, 48);

    pulse(3); chk("div_1", div_sel, 1);
    pulse(3); chk("div_2", div_sel, 2);
    wait_pe(ok); chk("pe_seen_3", ok, 1);
    measure(len, hi);
    chk("period_div2", len, 1024);
    chk("high_div2", hi, 192);
    pulse(3); chk("div_3", div_sel, 3);
    pulse(3); chk("div_0", div_sel, 0);

    wait_pe(ok); chk("pe_seen_4", ok, 1);
    cyc(10);
    repeat (4) pulse(0);
    chk("duty_80", duty, 80);
    chk("mid_hi", pwm_out, 1);
    cyc(40); chk("mid_old_duty", pwm_out, 0);
    wait_pe(ok); chk("pe_seen_5", ok, 1);
    cyc(60); chk("new_duty", pwm_out, 1);
    press[2] = 1'b1;
    @(negedge clk);
    chk("stop_pwm", pwm_out, 0);
    chk("stop_running", running, 0);
    press[2] = 1'b0;
    cyc(2);

    press[1:0] = 2'b11;
    cyc(3);
    press = '0;
    cyc(2); chk("both_keys", duty, 80);

    pulse(2); chk("run_again", running, 1);
    press[0] = 1'b1;
    cyc(3); chk("pre_reset_step", duty, 88);
    n_reset = 1'b0;
    @(negedge clk);
    chk("rst2_duty", duty, 128);
    chk("rst2_running", running, 0);
    chk("rst2_pwm", pwm_out, 0);
    chk("rst2_div", div_sel, 0);
    chk("rst2_pe", period_end, 0);
    n_reset = 1'b1;
    cyc(20); chk("held_through_reset", duty, 128);
    press[0] = 1'b0;
    cyc(2);
    pulse(0); chk("repress", duty, 136);
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_key_ctrl.md
PWM_KEY_CTRL -- requirements
Module: pwm_key_ctrl

Interface
REQ-001 The block SHALL expose parameter DUTY_W, default 8, meaning duty and PWM counter width in bits.
REQ-002 The block SHALL expose parameter STEP, default 8, meaning duty increment/decrement per step event.
REQ-003 The block SHALL expose parameter DUTY_INIT, default 128, meaning duty value after reset.
REQ-004 The block SHALL expose parameter HOLD_CYC, default 25_000_000, meaning the number of held-key clk cycles before auto-repeat starts.
REQ-005 The block SHALL expose parameter REPEAT_CYC, default 5_000_000, meaning the number of clk cycles between auto-repeat steps.
REQ-006 clk  input  1  single system clock; all logic on rising edge.
REQ-007 n_reset  input  1  reset, synchronous, active-low.
REQ-008 press  input  4  debounced key levels, 1 = pressed, synchronous to clk; [0] up, [1] down, [2] run/stop, [3] divider select.
REQ-009 pwm_out  output  1  PWM waveform.
REQ-010 duty  output  DUTY_W  current commanded duty.
REQ-011 running  output  1  1 = RUN state.
REQ-012 div_sel  output  2  current tick divider select.
REQ-013 period_end  output  1  one-cycle pulse at each PWM period wrap while running.

Function
REQ-014 Press events SHALL be rising edges of press[i], detected against a one-cycle registered copy of press; an event is acted on in the cycle after the edge appears on press.
REQ-015 The main FSM SHALL have states STOP and RUN; a press[2] event toggles STOP->RUN or RUN->STOP; running = 1 only in RUN.
REQ-016 A press[3] event SHALL increment div_sel modulo 4 (3 wraps to 0), in either state.
REQ-017 The tick SHALL assert once every 2^div_sel clk cycles in RUN (div 1, 2, 4, 8), from a 3-bit prescaler; the prescaler SHALL be 0 and tick SHALL be 0 in STOP.
REQ-018 The PWM counter SHALL increment on each tick, wrapping from 2^DUTY_W-1 to 0; it SHALL be held at 0 in STOP.
REQ-019 duty SHALL be copied into a shadow duty_active on the STOP->RUN transition and on every tick at which the counter wraps; duty changes SHALL NOT affect pwm_out mid-period.
REQ-020 pwm_out SHALL equal (running AND counter < duty_active), registered; duty_active = 0 gives constant low; 2^DUTY_W-1 gives high for all but one count.
REQ-021 period_end SHALL pulse for exactly one clk cycle on each wrap tick in RUN.
REQ-022 A press[0] step SHALL set duty = min(duty+STEP, 2^DUTY_W-1); a press[1] step SHALL set duty = max(duty-STEP, 0); saturation, never wrap-around.
REQ-023 Up/down steps SHALL be accepted in both STOP and RUN.
REQ-024 Rising edges of press[0] and press[1] in the same cycle, or either while the other is held, SHALL produce no step.
REQ-025 The repeat FSM SHALL have states R_IDLE, R_HOLD, R_REPEAT, and a cycle counter wide enough for max(HOLD_CYC, REPEAT_CYC).
REQ-026 R_IDLE->R_HOLD on a single accepted up/down event (which itself steps once); counter cleared.
REQ-027 R_HOLD->R_REPEAT when the same key has been held HOLD_CYC cycles; one step issued on entry; counter cleared.
REQ-028 In R_REPEAT, one step SHALL be issued every REPEAT_CYC cycles while the key remains held.
REQ-029 Release of the active key, or assertion of the opposite key, SHALL return the repeat FSM to R_IDLE next cycle with no further step.
REQ-030 press[2] and press[3] events SHALL be independent of, and may coincide with, up/down steps; all take effect in the same cycle.
REQ-031 The RUN->STOP transition SHALL force pwm_out low on the next clk edge and clear counter and prescaler.

Reset
REQ-032 When n_reset = 0 at a clk edge: FSM = STOP, repeat FSM = R_IDLE, duty = DUTY_INIT, duty_active = 0, div_sel = 0, counters = 0, registered press copy = 0, pwm_out = 0, running = 0, period_end = 0.
REQ-033 Reset mid-operation SHALL abandon any period or repeat sequence; a key still held at reset release SHALL NOT generate an event until released and pressed again.

Verification (DUTY_W=8, STEP=8, HOLD_CYC=10, REPEAT_CYC=4)
REQ-034 Reset, press[2] pulse, duty 128, div_sel 0 -> running=1, pwm_out high 128 of every 256 cycles, period_end every 256 cycles.
REQ-035 duty=248, press[0] pulse twice -> duty 255 then 255 (saturate); duty=8, press[1] twice -> 0, 0; pwm_out constant low after next wrap.
REQ-036 Hold press[0] 30 cycles from duty 0 -> steps at event, +10, +14, +18, +22, +26 cycles -> duty 48; release -> no further change.
REQ-037 press[3] pulsed 4 times while running -> div_sel 1,2,3,0; at div_sel 2 PWM period = 1024 clk cycles.
REQ-038 Change duty mid-period while running -> pwm_out unchanged until next period_end; press[2] mid-period -> pwm_out 0 next cycle, running 0.
REQ-039 press[0] and press[1] rise together -> duty unchanged; n_reset low 1 cycle while running with press[0] held -> all REQ-032 values, no step until press[0] re-pressed.
